rm_hdr_out_arb: RTL and testbench
=================================

Name: rm_hdr_out_arb

Overview:
Packet-granular round-robin arbiter that shares one header-stripped output stream among NUM_QUEUES header-removal queues.
It sits downstream of the per-port header-removal FIFOs and feeds the single MAC/DMA egress datapath.
It uses the codebase push interface (wr/rdy, ctrl/data word pairs).
A grant is held from the first word of a packet through its EOP word, so packets never interleave.

Parameters:
DATA_WIDTH, 64, data word width in bits.
CTRL_WIDTH, DATA_WIDTH/8, ctrl width; nonzero ctrl marks the EOP word (byte mask).
NUM_QUEUES, 4, number of requesting queues (2..8).
CNT_WIDTH, 32, width of the statistics counters.

Ports:
clk  in  1  core clock.
reset  in  1  asynchronous, active-high reset.
in_req  in  NUM_QUEUES  bit i high = queue i holds at least one complete packet.
in_data  in  NUM_QUEUES*DATA_WIDTH  flattened data; queue i occupies [i*DATA_WIDTH +: DATA_WIDTH].
in_ctrl  in  NUM_QUEUES*CTRL_WIDTH  flattened ctrl, same packing.
in_wr  in  NUM_QUEUES  word strobe per queue.
in_rdy  out  NUM_QUEUES  per-queue ready, combinational.
out_data  out  DATA_WIDTH  registered output data.
out_ctrl  out  CTRL_WIDTH  registered output ctrl.
out_wr  out  1  registered output strobe.
out_rdy  in  1  downstream ready.
cur_grant  out  log2(NUM_QUEUES)  index of the queue currently or last granted.
busy  out  1  high while in XFER.
proto_err  out  1  sticky; set on a write from a non-ready queue.
pkt_cnt  out  CNT_WIDTH  EOP words forwarded; wraps.
word_cnt  out  CNT_WIDTH  words forwarded; wraps.

Behaviour:
- Reset (asynchronous, active-high):
  - state=IDLE.
  - All outputs 0.
  - last_grant=NUM_QUEUES-1, so queue 0 wins first.
  - proto_err=0; counters=0.
  - Reset mid-packet abandons the packet. No EOP is synthesised.
- IDLE:
  - in_rdy=0.
  - If |in_req, pick the first set bit scanning from (last_grant+1) mod NUM_QUEUES upward with wrap.
  - Register grant and cur_grant, then go to XFER next cycle. Arbitration latency is 1 cycle.
  - If no request, stay in IDLE.
- XFER:
  - in_rdy[g]=out_rdy; all other in_rdy bits are 0.
  - A source may assert in_wr[g] only in a cycle where in_rdy[g]=1.
  - An accepted word appears on out_data/out_ctrl with out_wr=1 on the next cycle. Latency is exactly 1 cycle.
  - out_data/out_ctrl hold their last value when out_wr=0.
  - Accepted word with |ctrl!=0 (EOP):
    - last_grant<=g; state<=IDLE.
    - pkt_cnt increments.
    - There is one idle arbitration cycle between packets.
  - word_cnt increments on every accepted word.
  - in_req[g] dropping mid-packet is ignored; the grant holds until EOP.
  - out_rdy low mid-packet: in_rdy[g] drops the same cycle, with no loss and no duplication.
- Protocol violations:
  - in_wr[i]=1 while in_rdy[i]=0 (any state): the word is dropped and proto_err<=1.
  - proto_err clears only on reset.
- Arbiter fairness:
  - A queue that is continuously requesting waits at most NUM_QUEUES-1 packets.
  - A lone requester is granted back-to-back, with an idle cycle between packets.
- Counters wrap from all-ones to 0 without saturation.

Test Plan:
- Reset, then in_req=4'b0001. Queue 0 sends 3 words, ctrl=0,0,8'h80 -> in_rdy=4'b0001 from cycle 2; out_wr high on 3 consecutive cycles, each one cycle after its write; pkt_cnt=1, word_cnt=3; busy falls after EOP.
- in_req=4'b1111 held; each queue sends 2-word packets -> grant order 0,1,2,3,0,…; cur_grant matches; no interleaving; one idle cycle between packets.
- Queue 2 mid-packet; out_rdy low for 4 cycles, source obeys in_rdy -> in_rdy[2]=0 during the stall; output word sequence contiguous, none lost or duplicated.
- Queue 1 pulses in_wr while queue 3 is granted -> queue 1 word absent from output; proto_err=1 and stays 1 until reset.
- Assert reset asynchronously mid-packet on queue 0, release, then in_req=4'b0110 -> outputs 0 immediately; after release queue 1 is granted first.
- Preload word_cnt near all-ones via a long run (or force), send 2 words -> word_cnt wraps to 1 with no saturation.

Source files
------------

// File: rtl/rm_hdr_out_arb.sv
// rm_hdr_out_arb: packet-granular round-robin arbiter merging NUM_QUEUES
// header-stripped push streams (wr/rdy, ctrl/data) into one egress stream.
// A grant is held from the first word of a packet through its EOP word.
module rm_hdr_out_arb #(
    parameter int DATA_WIDTH = 64,
    parameter int CTRL_WIDTH = DATA_WIDTH / 8,
    parameter int NUM_QUEUES = 4,
    parameter int CNT_WIDTH  = 32,
    localparam int GW        = $clog2(NUM_QUEUES)
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [NUM_QUEUES-1:0]            in_req,
    input  logic [NUM_QUEUES*DATA_WIDTH-1:0] in_data,
    input  logic [NUM_QUEUES*CTRL_WIDTH-1:0] in_ctrl,
    input  logic [NUM_QUEUES-1:0]            in_wr,
    output logic [NUM_QUEUES-1:0]            in_rdy,
    output logic [DATA_WIDTH-1:0]            out_data,
    output logic [CTRL_WIDTH-1:0]            out_ctrl,
    output logic                             out_wr,
    input  logic                             out_rdy,
    output logic [GW-1:0]                    cur_grant,
    output logic                             busy,
    output logic                             proto_err,
    output logic [CNT_WIDTH-1:0]             pkt_cnt,
    output logic [CNT_WIDTH-1:0]             word_cnt
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_XFER = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [GW-1:0]           grant_q;
    logic [GW-1:0]           last_grant_q;
    logic [DATA_WIDTH-1:0]   out_data_q;
    logic [CTRL_WIDTH-1:0]   out_ctrl_q;
    logic                    out_wr_q;
    logic                    proto_err_q;
    logic [CNT_WIDTH-1:0]    pkt_cnt_q;
    logic [CNT_WIDTH-1:0]    word_cnt_q;

    logic [NUM_QUEUES-1:0]   in_rdy_s;
    logic                    pick_found_s;
    logic [GW-1:0]           pick_idx_s;
    logic [DATA_WIDTH-1:0]   sel_data_s;
    logic [CTRL_WIDTH-1:0]   sel_ctrl_s;
    logic                    accept_s;
    logic                    eop_s;
    logic                    proto_viol_s;

    // Round-robin pick: first requesting queue after last_grant, with wrap.
    always_comb begin
        logic [GW:0] cand;
        pick_found_s = 1'b0;
        pick_idx_s   = '0;
        cand         = '0;
        for (int k = 1; k <= NUM_QUEUES; k++) begin
            cand = {1'b0, last_grant_q} + (GW+1)'(k);
            if (cand >= (GW+1)'(NUM_QUEUES)) begin
                cand = cand - (GW+1)'(NUM_QUEUES);
            end else begin
                cand = cand;
            end
            if (!pick_found_s && in_req[cand[GW-1:0]]) begin
                pick_found_s = 1'b1;
                pick_idx_s   = cand[GW-1:0];
            end else begin
                pick_found_s = pick_found_s;
            end
        end
    end

    // Granted queue's word and the accept / EOP / protocol-violation strobes.
    always_comb begin
        sel_data_s   = in_data[grant_q*DATA_WIDTH +: DATA_WIDTH];
        sel_ctrl_s   = in_ctrl[grant_q*CTRL_WIDTH +: CTRL_WIDTH];
        accept_s     = in_rdy_s[grant_q] & in_wr[grant_q];
        eop_s        = accept_s & (|sel_ctrl_s);
        proto_viol_s = |(in_wr & ~in_rdy_s);
    end

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: arbitrate in IDLE, hold grant in XFER until EOP.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (pick_found_s) begin
                    state_d = S_XFER;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_XFER: begin
                if (eop_s) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_XFER;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs: only the granted queue sees downstream ready, and only in XFER.
    always_comb begin
        in_rdy_s = '0;
        case (state_q)
            S_XFER:  in_rdy_s[grant_q] = out_rdy;
            S_IDLE:  in_rdy_s = '0;
            default: in_rdy_s = '0;
        endcase
    end

    // Grant bookkeeping, registered output stage, sticky error and counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            grant_q      <= '0;
            last_grant_q <= GW'(NUM_QUEUES - 1);
            out_data_q   <= '0;
            out_ctrl_q   <= '0;
            out_wr_q     <= 1'b0;
            proto_err_q  <= 1'b0;
            pkt_cnt_q    <= '0;
            word_cnt_q   <= '0;
        end else begin
            if (state_q == S_IDLE && pick_found_s) begin
                grant_q <= pick_idx_s;
            end
            out_wr_q <= accept_s;
            if (accept_s) begin
                out_data_q <= sel_data_s;
                out_ctrl_q <= sel_ctrl_s;
                word_cnt_q <= word_cnt_q + CNT_WIDTH'(1);
            end
            if (eop_s) begin
                pkt_cnt_q    <= pkt_cnt_q + CNT_WIDTH'(1);
                last_grant_q <= grant_q;
            end
            if (proto_viol_s) begin
                proto_err_q <= 1'b1;
            end
        end
    end

    assign in_rdy    = in_rdy_s;
    assign out_data  = out_data_q;
    assign out_ctrl  = out_ctrl_q;
    assign out_wr    = out_wr_q;
    assign cur_grant = grant_q;
    assign busy      = (state_q == S_XFER);
    assign proto_err = proto_err_q;
    assign pkt_cnt   = pkt_cnt_q;
    assign word_cnt  = word_cnt_q;

endmodule

// File: tb/tb_rm_hdr_out_arb.sv
// Self-checking bench for rm_hdr_out_arb: table of arbitration vectors,
// hand-written corner sequences, and an output scoreboard queue.
module tb_rm_hdr_out_arb;

    localparam int DW = 64;
    localparam int CW = 8;
    localparam int NQ = 4;
    localparam int KW = 4;   // narrow counters so the wrap is reached quickly

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [NQ-1:0]     in_req = '0;
    logic [NQ*DW-1:0]  in_data = '0;
    logic [NQ*CW-1:0]  in_ctrl = '0;
    logic [NQ-1:0]     in_wr = '0;
    logic [NQ-1:0]     in_rdy;
    logic [DW-1:0]     out_data;
    logic [CW-1:0]     out_ctrl;
    logic              out_wr;
    logic              out_rdy = 1'b1;
    logic [1:0]        cur_grant;
    logic              busy;
    logic              proto_err;
    logic [KW-1:0]     pkt_cnt;
    logic [KW-1:0]     word_cnt;

    rm_hdr_out_arb #(.DATA_WIDTH(DW), .CTRL_WIDTH(CW), .NUM_QUEUES(NQ), .CNT_WIDTH(KW)) dut (
        .clk(clk), .reset(reset), .in_req(in_req), .in_data(in_data), .in_ctrl(in_ctrl),
        .in_wr(in_wr), .in_rdy(in_rdy), .out_data(out_data), .out_ctrl(out_ctrl),
        .out_wr(out_wr), .out_rdy(out_rdy), .cur_grant(cur_grant), .busy(busy),
        .proto_err(proto_err), .pkt_cnt(pkt_cnt), .word_cnt(word_cnt)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int pkt_id = 0;
    int exp_words = 0;
    int exp_pkts = 0;

    typedef struct {
        logic [DW-1:0] data;
        logic [CW-1:0] ctrl;
        int            cyc;
    } exp_t;
    exp_t exp_q[$];

    typedef struct {
        logic [NQ-1:0] req;
        int            exp_g;
        int            n;
        int            stall_at;
    } vec_t;
    vec_t vecs[10];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard: every output word must match the oldest pushed word, one cycle later.
    always @(negedge clk) begin : mon
        exp_t e;
        if (!reset && out_wr) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL out_unexpected: got word %0h expected none", out_data);
            end else begin
                e = exp_q.pop_front();
                chk("out_data", out_data, e.data);
                chk("out_ctrl", 64'(out_ctrl), 64'(e.ctrl));
                chk("out_latency", 64'(cyc), 64'(e.cyc + 1));
            end
        end
    end

    task automatic wait_busy();
        for (int i = 0; i < 20 && !busy; i++) begin
            @(posedge clk); #1;
        end
        chk("busy_grant", 64'(busy), 64'(1));
    endtask

    task automatic drive_word(input int q, input int w, input bit eop);
        logic [DW-1:0] d;
        logic [CW-1:0] c;
        d = {8'(q), 8'(w), 16'hC0DE, 32'(pkt_id)};
        c = eop ? 8'h80 : 8'h00;
        in_data[q*DW +: DW] = d;
        in_ctrl[q*CW +: CW] = c;
        in_wr[q] = 1'b1;
        exp_q.push_back('{d, c, cyc});
        @(posedge clk); #1;
        in_wr = '0;
        in_ctrl = '0;
        exp_words++;
        if (eop) exp_pkts++;
    endtask

    task automatic send_pkt(input int q, input int n, input int stall_at);
        int t;
        for (int w = 0; w < n; w++) begin
            if (w == stall_at) begin
                out_rdy = 1'b0;
                repeat (4) begin
                    #1;
                    chk("stall_in_rdy", 64'(in_rdy), 64'(0));
                    @(posedge clk); #1;
                end
                out_rdy = 1'b1;
            end
            #1;
            t = 0;
            while (!in_rdy[q] && t < 20) begin
                @(posedge clk); #1;
                t++;
            end
            chk("in_rdy_grant", 64'(in_rdy), 64'(1) << q);
            if (!in_rdy[q]) return;
            drive_word(q, w, w == n - 1);
        end
        pkt_id++;
        chk("idle_after_eop", 64'(busy), 64'(0));
        chk("pkt_cnt", 64'(pkt_cnt), 64'(exp_pkts % 16));
        chk("word_cnt", 64'(word_cnt), 64'(exp_words % 16));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{4'b1111, 1, 2, -1};
        vecs[1] = '{4'b1111, 2, 2, -1};
        vecs[2] = '{4'b1111, 3, 2, -1};
        vecs[3] = '{4'b1111, 0, 2, -1};
        vecs[4] = '{4'b1111, 1, 2, -1};
        vecs[5] = '{4'b0101, 2, 2, -1};
        vecs[6] = '{4'b0101, 0, 1, -1};
        vecs[7] = '{4'b1000, 3, 2, -1};
        vecs[8] = '{4'b0100, 2, 3,  1};
        vecs[9] = '{4'b0011, 0, 2, -1};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_wr", 64'(out_wr), 64'(0));
        chk("rst_out_data", out_data, 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_cur_grant", 64'(cur_grant), 64'(0));
        chk("rst_proto_err", 64'(proto_err), 64'(0));
        chk("rst_in_rdy", 64'(in_rdy), 64'(0));
        reset = 1'b0;

        // Single 3-word packet from queue 0
        in_req = 4'b0001;
        #1;
        chk("idle_in_rdy", 64'(in_rdy), 64'(0));
        wait_busy();
        chk("cur_grant_first", 64'(cur_grant), 64'(0));
        send_pkt(0, 3, -1);
        chk("pkt_cnt_one", 64'(pkt_cnt), 64'(1));
        chk("word_cnt_three", 64'(word_cnt), 64'(3));
        in_req = '0;

        // Table-driven arbitration vectors
        for (int i = 0; i < 10; i++) begin
            in_req = vecs[i].req;
            wait_busy();
            chk("cur_grant_vec", 64'(cur_grant), 64'(vecs[i].exp_g));
            if (vecs[i].stall_at >= 0) in_req = '0;
            send_pkt(vecs[i].exp_g, vecs[i].n, vecs[i].stall_at);
        end
        in_req = '0;

        // Protocol violation from queue 1 while queue 3 is granted
        in_req = 4'b1000;
        wait_busy();
        chk("cur_grant_proto", 64'(cur_grant), 64'(3));
        in_req = '0;
        in_data[1*DW +: DW] = 64'hDEAD_BEEF_0000_0001;
        in_ctrl[1*CW +: CW] = 8'h80;
        in_wr[1] = 1'b1;
        @(posedge clk); #1;
        in_wr = '0;
        in_ctrl = '0;
        chk("proto_err_set", 64'(proto_err), 64'(1));
        send_pkt(3, 2, -1);
        repeat (3) @(posedge clk);
        #1;
        chk("proto_err_sticky", 64'(proto_err), 64'(1));

        // Asynchronous reset in the middle of a queue 0 packet
        in_req = 4'b0001;
        wait_busy();
        chk("cur_grant_rst", 64'(cur_grant), 64'(0));
        drive_word(0, 0, 1'b0);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_out_wr", 64'(out_wr), 64'(0));
        chk("arst_out_data", out_data, 64'(0));
        chk("arst_busy", 64'(busy), 64'(0));
        chk("arst_word_cnt", 64'(word_cnt), 64'(0));
        chk("arst_proto_err", 64'(proto_err), 64'(0));
        chk("arst_in_rdy", 64'(in_rdy), 64'(0));
        chk("arst_sb_empty", 64'(exp_q.size()), 64'(0));
        exp_words = 0;
        exp_pkts = 0;
        pkt_id++;
        in_req = '0;
        repeat (2) @(posedge clk);
        #3;
        reset = 1'b0;
        in_req = 4'b0110;
        wait_busy();
        chk("grant_after_rst", 64'(cur_grant), 64'(1));
        send_pkt(1, 2, -1);
        in_req = '0;

        // Lone requester back-to-back; word_cnt walks to all-ones then wraps
        in_req = 4'b0100;
        wait_busy();
        chk("cur_grant_lone1", 64'(cur_grant), 64'(2));
        send_pkt(2, 15 - exp_words, -1);
        chk("word_cnt_full", 64'(word_cnt), 64'(15));
        wait_busy();
        chk("cur_grant_lone2", 64'(cur_grant), 64'(2));
        send_pkt(2, 2, -1);
        chk("word_cnt_wrap", 64'(word_cnt), 64'(1));
        in_req = '0;

        repeat (3) @(posedge clk);
        #1;
        chk("sb_drained", 64'(exp_q.size()), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
